// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor. The carry chain is cut into STAGES slices,
// one slice resolved per register stage, with a valid/ready handshake on both sides.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 34,
    parameter int GROUP  = 8,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int SLICE = (WIDTH + STAGES - 1) / STAGES;
    localparam int PW    = SLICE * STAGES;
    localparam int NR    = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int L     = STAGES - 1;

    // Handshake: a beat transfers on in_valid && in_ready, a result retires on
    // out_valid && out_ready; every stage moves together whenever the output slot is free or draining.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Inter-stage registers: operands still to be resolved, partial sum, slice carry, valid.
    logic [PW-1:0] a_r [NR];
    logic [PW-1:0] b_r [NR];
    logic [PW-1:0] s_r [NR];
    logic [NR-1:0] c_r;
    logic [NR-1:0] v_r;

    logic [WIDTH-1:0]  yb;
    logic [PW-1:0]     st_a [STAGES];
    logic [PW-1:0]     st_b [STAGES];
    logic [PW-1:0]     st_s [STAGES];
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] st_v;
    logic [PW-1:0]     nx_s [STAGES];
    logic [STAGES-1:0] nx_c;
    logic [SLICE:0]    slice_r;
    logic [PW:0]       fin_ext;
    logic [WIDTH-1:0]  fin_sum;
    logic              fin_cout;
    logic              fin_ovf;
    logic              fin_zero;

    // Group lookahead over one slice: per-group G/P folded into the group carry chain,
    // bits inside a group take their carry from the group carry-in.
    function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic             ci);
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] s;
        logic             gc;
        logic             bc;
        logic             grp_g;
        logic             grp_p;
        g     = a & b;
        p     = a ^ b;
        s     = '0;
        gc    = ci;
        bc    = ci;
        grp_g = 1'b0;
        grp_p = 1'b1;
        for (int i = 0; i < SLICE; i++) begin
            if (i % GROUP == 0) begin
                grp_g = 1'b0;
                grp_p = 1'b1;
                bc    = gc;
            end
            s[i]  = p[i] ^ bc;
            bc    = g[i] | (p[i] & bc);
            grp_g = g[i] | (p[i] & grp_g);
            grp_p = grp_p & p[i];
            if ((i % GROUP == GROUP - 1) || (i == SLICE - 1)) begin
                gc = grp_g | (grp_p & gc);
            end
        end
        return {gc, s};
    endfunction

    always_comb begin
        yb      = sub ? ~y : y;
        slice_r = '0;
        st_a[0] = PW'(x);
        st_b[0] = PW'(yb);
        st_s[0] = '0;
        st_c[0] = sub | cin;
        st_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k] = a_r[k-1];
            st_b[k] = b_r[k-1];
            st_s[k] = s_r[k-1];
            st_c[k] = c_r[k-1];
            st_v[k] = v_r[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice_r = slice_add(st_a[k][k*SLICE +: SLICE], st_b[k][k*SLICE +: SLICE], st_c[k]);
            nx_s[k] = st_s[k];
            nx_s[k][k*SLICE +: SLICE] = slice_r[SLICE-1:0];
            nx_c[k] = slice_r[SLICE];
        end
        // Operands are zero-padded above WIDTH, so the carry out of bit WIDTH-1 lands at bit WIDTH.
        fin_ext  = {nx_c[L], nx_s[L]};
        fin_sum  = fin_ext[WIDTH-1:0];
        fin_cout = fin_ext[WIDTH];
        fin_ovf  = (st_a[L][WIDTH-1] == st_b[L][WIDTH-1]) && (fin_sum[WIDTH-1] != st_a[L][WIDTH-1]);
        fin_zero = (fin_sum == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NR; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
            c_r       <= '0;
            v_r       <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_r[k] <= st_a[k];
                b_r[k] <= st_b[k];
                s_r[k] <= nx_s[k];
                c_r[k] <= nx_c[k];
                v_r[k] <= st_v[k];
            end
            out_valid <= st_v[L];
            sum       <= fin_sum;
            cout      <= fin_cout;
            overflow  <= fin_ovf;
            zero      <= fin_zero;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: three configurations share one stimulus stream, each
// scored against an arithmetic reference model through its own expected queue.
module tb_pipelined_cla_addsub;
    localparam int ND = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic          in_valid;
    logic          out_ready;
    logic          sub;
    logic          cin;
    logic [33:0]   x;
    logic [33:0]   y;
    logic [ND-1:0] in_ready;
    logic [ND-1:0] out_valid;
    logic [ND-1:0] cout;
    logic [ND-1:0] overflow;
    logic [ND-1:0] zero;
    logic [33:0]   sum_a;
    logic [16:0]   sum_b;
    logic [33:0]   sum_c;
    logic [36:0]   res [ND];

    int            checks = 0;
    int            errors = 0;
    int            widths [ND] = '{34, 17, 34};
    int            accepted [ND] = '{0, 0, 0};
    logic [36:0]   exp_q [ND][$];
    logic [36:0]   held [ND];
    logic [ND-1:0] hold_v = '0;

    pipelined_cla_addsub #(.WIDTH(34), .GROUP(8), .STAGES(2)) dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
        .x(x), .y(y), .sub(sub), .cin(cin), .out_valid(out_valid[0]), .out_ready(out_ready),
        .sum(sum_a), .cout(cout[0]), .overflow(overflow[0]), .zero(zero[0]));

    pipelined_cla_addsub #(.WIDTH(17), .GROUP(4), .STAGES(3)) dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
        .x(x[16:0]), .y(y[16:0]), .sub(sub), .cin(cin), .out_valid(out_valid[1]), .out_ready(out_ready),
        .sum(sum_b), .cout(cout[1]), .overflow(overflow[1]), .zero(zero[1]));

    pipelined_cla_addsub #(.WIDTH(34), .GROUP(8), .STAGES(1)) dut_c (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]),
        .x(x), .y(y), .sub(sub), .cin(cin), .out_valid(out_valid[2]), .out_ready(out_ready),
        .sum(sum_c), .cout(cout[2]), .overflow(overflow[2]), .zero(zero[2]));

    assign res[0] = {overflow[0], zero[0], cout[0], sum_a};
    assign res[1] = {overflow[1], zero[1], cout[1], 17'd0, sum_b};
    assign res[2] = {overflow[2], zero[2], cout[2], sum_c};

    // Reference: {overflow, zero, cout, sum} from integer arithmetic on w-bit operands.
    function automatic logic [36:0] model(input int w, input logic [33:0] xv, input logic [33:0] yv,
                                          input logic s, input logic c);
        longint m, half, xu, yu, ybu, full, sm, sx, sy, t;
        logic   ovf, cy;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        xu   = longint'(xv) & m;
        yu   = longint'(yv) & m;
        ybu  = s ? (~yu & m) : yu;
        full = xu + ybu + (s ? longint'(1) : longint'(c));
        sm   = full & m;
        sx   = (xu >= half) ? xu - 2 * half : xu;
        sy   = (yu >= half) ? yu - 2 * half : yu;
        t    = s ? sx - sy : sx + sy + longint'(c);
        ovf  = (t < -half) || (t >= half);
        cy   = ((full >> w) & 1) != 0;
        return {ovf, sm == 0, cy, 34'(sm)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push at acceptance, compare at retirement, verify outputs hold while stalled.
    always @(negedge clock) begin
        for (int d = 0; d < ND; d++) begin
            if (reset) begin
                exp_q[d].delete();
                hold_v[d] = 1'b0;
            end else begin
                if (hold_v[d])
                    chk($sformatf("stall_hold_d%0d", d), 64'({out_valid[d], res[d]}), 64'({1'b1, held[d]}));
                if (in_valid && in_ready[d]) begin
                    exp_q[d].push_back(model(widths[d], x, y, sub, cin));
                    accepted[d]++;
                end
                if (out_valid[d] && out_ready) begin
                    if (exp_q[d].size() == 0)
                        chk($sformatf("spurious_result_d%0d", d), 64'(out_valid[d]), 64'(0));
                    else
                        chk($sformatf("result_d%0d", d), 64'(res[d]), 64'(exp_q[d].pop_front()));
                end
                hold_v[d] = out_valid[d] && !out_ready;
                held[d]   = res[d];
            end
        end
    end

    task automatic rand_operands();
        case ($urandom_range(0, 5))
            0: x = '1;
            1: x = '0;
            2: x = 34'h1_FFFF_FFFF;
            3: x = 34'h0_0000_FFFF;
            default: begin
                x[31:0]  = $urandom();
                x[33:32] = 2'($urandom_range(0, 3));
            end
        endcase
        case ($urandom_range(0, 4))
            0: y = '1;
            1: y = '0;
            2: y = x;
            default: begin
                y[31:0]  = $urandom();
                y[33:32] = 2'($urandom_range(0, 3));
            end
        endcase
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
    endtask

    // One beat into an idle pipe; checks the per-configuration latency and returns A's result.
    task automatic send_one(input logic [33:0] xv, input logic [33:0] yv, input logic s,
                            input logic c, output logic [36:0] ra);
        x = xv; y = yv; sub = s; cin = c; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("latency1_out_valid", 64'(out_valid), 64'(3'b100));
        @(posedge clock); #1;
        chk("latency2_out_valid", 64'(out_valid), 64'(3'b001));
        ra = res[0];
        @(posedge clock); #1;
        chk("latency3_out_valid", 64'(out_valid), 64'(3'b010));
        @(posedge clock); #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, "_drained"}, 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'(0));
        chk({tag, "_no_extra"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        logic [36:0] ra;
        int          n;
        int          start;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        for (int d = 0; d < ND; d++)
            chk($sformatf("reset_state_d%0d", d), 64'({out_valid[d], res[d]}), 64'(0));
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed corner cases; the scoreboard also checks B and C on each.
        send_one(34'h1_FFFF_FFFF, 34'h1, 1'b0, 1'b0, ra);
        chk("t1_max_pos_plus_one", 64'(ra), 64'({1'b1, 1'b0, 1'b0, 34'h2_0000_0000}));
        send_one(34'h5, 34'h7, 1'b1, 1'b0, ra);
        chk("t2_sub_borrow", 64'(ra), 64'({1'b0, 1'b0, 1'b0, 34'h3_FFFF_FFFE}));
        send_one(34'h7, 34'h7, 1'b1, 1'b1, ra);
        chk("t2_sub_equal", 64'(ra), 64'({1'b0, 1'b1, 1'b1, 34'h0}));
        send_one(34'h3_FFFF_FFFF, 34'h0, 1'b0, 1'b1, ra);
        chk("t3_full_ripple", 64'(ra), 64'({1'b0, 1'b1, 1'b1, 34'h0}));
        send_one(34'h0_0000_FFFF, 34'h1, 1'b0, 1'b0, ra);
        send_one(34'h0_0001_FFFF, 34'h0, 1'b0, 1'b1, ra);
        send_one(34'h0_0001_0000, 34'h1, 1'b1, 1'b0, ra);

        // Back-to-back stream with a three-cycle output stall in the middle.
        for (int i = 0; i < 10; i++) begin
            rand_operands();
            in_valid = 1'b1;
            if (i == 5) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(posedge clock); #1;
                    chk("stall_in_ready", 64'(in_ready), 64'(0));
                    chk("stall_out_valid", 64'(out_valid), 64'(3'b111));
                end
                out_ready = 1'b1;
            end
            if (i >= 3) chk("stream_back_to_back", 64'(out_valid), 64'(3'b111));
            @(posedge clock); #1;
        end
        drain("stream");

        // Reset with beats in flight.
        rand_operands(); in_valid = 1'b1;
        @(posedge clock); #1;
        rand_operands();
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("pre_reset_out_valid", 64'(out_valid), 64'(3'b101));
        reset = 1'b1;
        #1;
        chk("reset_async_out_valid", 64'(out_valid), 64'(0));
        chk("reset_async_result_a", 64'(res[0]), 64'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            chk("post_reset_no_stale", 64'(out_valid), 64'(0));
        end

        // Random traffic with random bubbles and backpressure.
        start = accepted[0];
        n = 0;
        while (accepted[0] - start < 10000 && n < 60000) begin
            rand_operands();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 4) != 0);
            @(posedge clock); #1;
            n++;
        end
        chk("random_beats_accepted", 64'(accepted[0] - start >= 10000), 64'(1));
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
